pipe_ctrl_stage: RTL

PIPE_CTRL_STAGE -- requirements
Module: pipe_ctrl_stage

---
 rtl/pipe_pkg.sv | 35 +++
 rtl/sat_counter.sv | 35 +++
 rtl/pipe_ctrl_stage.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// ----------------------------------------------------------------------------
// pipe_pkg
// Purpose : Shared types and constants for the decode->execute pipeline
//           control stage.
// Contents:
//   ctrl_t       packed decode/execute control word (19 bits)
//   CTRL_W       width of ctrl_t
//   CTRL_BUBBLE  control word of a bubble (all zeros, no side effects)
//   ctrl_is_bubble() true when none of the side-effect fields are set
// ----------------------------------------------------------------------------
package pipe_pkg;

  typedef struct packed {
    logic       PCSrc;
    logic       RegWrite;
    logic       MemtoReg;
    logic       MemWrite;
    logic       Branch;
    logic       ALUSrc;
    logic [1:0] FlagWrite;
    logic [2:0] ALUControl;
    logic [3:0] Cond;
    logic [3:0] Flags;
  } ctrl_t;

  localparam int unsigned CTRL_W = $bits(ctrl_t);

  localparam ctrl_t CTRL_BUBBLE = '0;

  // A word is harmless when it cannot change architectural state.
  function automatic logic ctrl_is_bubble(input ctrl_t c);
    return !(c.PCSrc || c.RegWrite || c.MemWrite || c.Branch || (|c.FlagWrite));
  endfunction

endpackage

// File: rtl/sat_counter.sv
// ----------------------------------------------------------------------------
// sat_counter
// Purpose : Up-counter that sticks at its all-ones maximum instead of
//           wrapping. Used for the stall-cycle statistic.
// Ports   :
//   i_clk    clock, rising edge
//   i_rst    asynchronous active-high reset, clears the count
//   i_inc    count this cycle
//   o_count  current count (WIDTH bits)
// ----------------------------------------------------------------------------
module sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;
  logic             w_at_max;

  assign w_at_max = &r_count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_inc && !w_at_max) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/pipe_ctrl_stage.sv
// ----------------------------------------------------------------------------
// pipe_ctrl_stage
// Purpose : Decode->execute pipeline register for the control word and a
//           payload, with valid/ready handshaking, flush and a saturating
//           stall-cycle counter.
// Build option:
//   PIPE_CTRL_STAGE_SKID_EN defined   -> two entries (main + skid), in_ready
//                                        is registered (= !skid_full).
//   PIPE_CTRL_STAGE_SKID_EN undefined -> one entry, in_ready is combinational
//                                        (!out_valid || out_ready).
// Ports:
//   clk        clock, rising edge
//   reset      asynchronous active-high reset
//   flush      kills every held entry on the next edge (drops same-cycle input)
//   in_valid   upstream has an instruction
//   in_ready   stage accepts input this cycle
//   in_ctrl    decode control word
//   in_data    decode payload (DATA_W)
//   out_valid  execute-side entry valid
//   out_ready  downstream consumes the entry this cycle
//   out_ctrl   execute control word; bubble (zeros) when out_valid=0
//   out_data   execute payload (DATA_W)
//   stall_cnt  saturating count of cycles with out_valid=1 and out_ready=0
// ----------------------------------------------------------------------------
module pipe_ctrl_stage
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  ctrl_t                  in_ctrl,
  input  logic [DATA_W-1:0]      in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output ctrl_t                  out_ctrl,
  output logic [DATA_W-1:0]      out_data,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  // Main entry: the one presented downstream.
  logic              r_main_valid;
  ctrl_t             r_main_ctrl;
  logic [DATA_W-1:0] r_main_data;

  logic w_in_xfer;
  logic w_out_xfer;
  logic w_stall;

  // flush wins over a same-cycle input, so it never counts as a transfer.
  assign w_in_xfer  = in_valid && in_ready && !flush;
  assign w_out_xfer = r_main_valid && out_ready;
  assign w_stall    = r_main_valid && !out_ready;

`ifdef PIPE_CTRL_STAGE_SKID_EN

  logic              r_skid_valid;
  ctrl_t             r_skid_ctrl;
  logic [DATA_W-1:0] r_skid_data;
  // Comes up 0 in reset and rises on the first edge afterwards.
  logic              r_in_ready;

  logic              w_main_valid_d;
  ctrl_t             w_main_ctrl_d;
  logic [DATA_W-1:0] w_main_data_d;
  logic              w_skid_valid_d;
  ctrl_t             w_skid_ctrl_d;
  logic [DATA_W-1:0] w_skid_data_d;

  assign in_ready = r_in_ready;

  // Drain first, then place the new entry in the oldest free slot; this
  // keeps FIFO order when skid promotes to main on the same edge.
  always_comb begin
    w_main_valid_d = r_main_valid;
    w_main_ctrl_d  = r_main_ctrl;
    w_main_data_d  = r_main_data;
    w_skid_valid_d = r_skid_valid;
    w_skid_ctrl_d  = r_skid_ctrl;
    w_skid_data_d  = r_skid_data;
    if (flush) begin
      w_main_valid_d = 1'b0;
      w_skid_valid_d = 1'b0;
    end else begin
      if (w_out_xfer) begin
        if (r_skid_valid) begin
          w_main_valid_d = 1'b1;
          w_main_ctrl_d  = r_skid_ctrl;
          w_main_data_d  = r_skid_data;
          w_skid_valid_d = 1'b0;
        end else begin
          w_main_valid_d = 1'b0;
        end
      end
      if (w_in_xfer) begin
        if (!w_main_valid_d) begin
          w_main_valid_d = 1'b1;
          w_main_ctrl_d  = in_ctrl;
          w_main_data_d  = in_data;
        end else if (!w_skid_valid_d) begin
          w_skid_valid_d = 1'b1;
          w_skid_ctrl_d  = in_ctrl;
          w_skid_data_d  = in_data;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_main_valid <= 1'b0;
      r_main_ctrl  <= CTRL_BUBBLE;
      r_main_data  <= '0;
      r_skid_valid <= 1'b0;
      r_skid_ctrl  <= CTRL_BUBBLE;
      r_skid_data  <= '0;
      r_in_ready   <= 1'b0;
    end else begin
      r_main_valid <= w_main_valid_d;
      r_main_ctrl  <= w_main_ctrl_d;
      r_main_data  <= w_main_data_d;
      r_skid_valid <= w_skid_valid_d;
      r_skid_ctrl  <= w_skid_ctrl_d;
      r_skid_data  <= w_skid_data_d;
      r_in_ready   <= !w_skid_valid_d;
    end
  end

`else

  // Accept when empty or when the held entry leaves on this same edge.
  assign in_ready = !r_main_valid || out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_main_valid <= 1'b0;
      r_main_ctrl  <= CTRL_BUBBLE;
      r_main_data  <= '0;
    end else if (flush) begin
      r_main_valid <= 1'b0;
    end else if (w_in_xfer) begin
      r_main_valid <= 1'b1;
      r_main_ctrl  <= in_ctrl;
      r_main_data  <= in_data;
    end else if (w_out_xfer) begin
      r_main_valid <= 1'b0;
    end
  end

`endif

  assign out_valid = r_main_valid;
  // Masking the whole word guarantees the side-effect fields are zero in a
  // bubble and keeps out_ctrl at zero through reset.
  assign out_ctrl  = r_main_valid ? r_main_ctrl : CTRL_BUBBLE;
  assign out_data  = r_main_data;

  sat_counter #(
    .WIDTH (STALL_CNT_W)
  ) u_stall_cnt (
    .i_clk   (clk),
    .i_rst   (reset),
    .i_inc   (w_stall),
    .o_count (stall_cnt)
  );

endmodule
